load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- MEM-stage block of the MIPS150 datapath, directly downstream of the ALU.
- Takes the ALU result as the effective address for LB/LH/LW/LBU/LHU/SB/SH/SW.
- Drives a ready-handshaked data-memory port with byte enables and lane-replicated store data.
- Returns aligned, sign- or zero-extended load data; stalls the pipeline while the access is outstanding.

Parameters:
TIMEOUT, 16, max cycles in REQ without MemReady before a bus error (≥2)

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Valid  input  1  MEM-stage instruction valid
Opcode  input  6  instruction opcode (Opcode.vh encodings: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B)
Addr  input  32  effective address from ALU Out
StoreData  input  32  rt value; low byte/half/word stored
DMemAddr  output  32  word address {Addr[31:2],2'b00}
DMemRE  output  1  read request
DMemWE  output  4  byte write enables, bit i = bits 8i+7:8i (little-endian lanes)
DMemWData  output  32  store data replicated across lanes
DMemRData  input  32  read data, valid when MemReady
MemReady  input  1  memory completes the request this cycle
LoadResult  output  32  extended load data
ResultValid  output  1  one-cycle pulse: load data valid / store done
Stall  output  1  hold upstream pipeline registers
AddrError  output  1  one-cycle pulse: misaligned access
BusError  output  1  one-cycle pulse: REQ timeout

Behaviour:
- States: IDLE, REQ, DONE, ERR. All outputs are registered except Stall.
- Reset (synchronous; wins over everything, including mid-REQ):
  - state ← IDLE; wait counter ← 0.
  - DMemRE, DMemWE, ResultValid, AddrError, BusError ← 0.
  - DMemAddr, DMemWData, LoadResult ← 0.
- Memory op = Opcode in the 8 listed codes; any other opcode, or Valid=0, leaves IDLE untouched with Stall=0.
- Misaligned: halfword ops with Addr[0]=1; word ops with Addr[1:0]≠0.
- IDLE, Valid & memop & aligned:
  - → REQ; latch opcode, Addr[1:0], word address, lane data.
  - Loads: DMemRE=1.
  - SB: DMemWE=1<<Addr[1:0], DMemWData={4{StoreData[7:0]}}.
  - SH: DMemWE=Addr[1]?4'b1100:4'b0011, DMemWData={2{StoreData[15:0]}}.
  - SW: DMemWE=4'b1111, DMemWData=StoreData.
- IDLE, Valid & memop & misaligned: → ERR with AddrError=1; no memory signals ever asserted.
- REQ:
  - Request signals are held stable; the wait counter increments each cycle.
  - MemReady=1 → DONE; drop DMemRE/DMemWE; on a load, register the extended lane of DMemRData into LoadResult.
    - LB/LBU: byte lane Addr[1:0].
    - LH/LHU: half Addr[1].
    - LW: full word.
    - LB/LH sign-extend; LBU/LHU zero-extend.
  - Counter reaches TIMEOUT-1 with MemReady=0 → ERR with BusError=1; drop requests; LoadResult unchanged.
  - MemReady in the same cycle as the timeout: MemReady wins.
- DONE: ResultValid=1 for one cycle (stores too; LoadResult keeps its prior value on stores) → IDLE.
- ERR: error pulse for one cycle → IDLE.
- Stall = (IDLE & Valid & memop) | REQ. Stall is 0 in DONE and ERR, so the pipeline advances at the end of those cycles.
- Valid/Opcode are ignored in REQ, DONE and ERR.
- Latency:
  - Access accepted at edge N → request visible cycle N+1.
  - MemReady at cycle N+k → ResultValid at cycle N+k+1.
  - Minimum 2 stall cycles per memory op.
- LoadResult holds its value until the next completed load.

Test Plan:
- After Reset: all outputs 0, state IDLE. Then LB, Addr=0x1003; MemReady=1 after 2 cycles with DMemRData=0x80FF1234 → DMemAddr=0x1000, DMemRE=1 held for 2 cycles, ResultValid pulse, LoadResult=0xFFFFFF80, Stall high exactly until DONE.
- LHU, Addr=0x1002, DMemRData=0x80FF1234, MemReady immediate → LoadResult=0x000080FF. Same with LH → 0xFFFF80FF. LW @0x1000 → 0x80FF1234.
- SB, Addr=0x2001, StoreData=0x123456AB → DMemWE=4'b0010, DMemWData=0xABABABAB, DMemRE=0. Then SH @0x2002, StoreData=0x00001234 → DMemWE=4'b1100, DMemWData=0x12341234.
- LW, Addr=0x1002 → AddrError one-cycle pulse; DMemRE/DMemWE never asserted; Stall high for one cycle only. Repeat for SH @0x2001.
- LW @0x1000 with MemReady held 0 → BusError at the TIMEOUT-th REQ cycle, LoadResult unchanged, back to IDLE. Second run asserts MemReady in the timeout cycle → ResultValid, no BusError.
- Reset asserted mid-REQ → next cycle all outputs 0, IDLE, no ResultValid. Also check opcode 0x00 (RTYPE) with Valid=1 → no activity, Stall=0.

Source files
------------

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: drives a ready-handshaked data-memory port,
// aligns and extends load data, and stalls the pipeline while busy.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Valid,
    input  logic [5:0]  Opcode,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic [31:0] DMemAddr,
    output logic        DMemRE,
    output logic [3:0]  DMemWE,
    output logic [31:0] DMemWData,
    input  logic [31:0] DMemRData,
    input  logic        MemReady,
    output logic [31:0] LoadResult,
    output logic        ResultValid,
    output logic        Stall,
    output logic        AddrError,
    output logic        BusError
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [5:0]        op_q, op_d;
    logic [1:0]        lo_q, lo_d;
    logic              load_q, load_d;
    logic [31:0]       addr_d, wdata_d, result_d;
    logic [3:0]        we_d;
    logic              re_d, rv_d, ae_d, be_d;
    logic              is_mem, is_load, misaligned;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [31:0]       load_ext;

    // Classify the incoming opcode and its alignment requirement
    always_comb begin
        is_mem     = 1'b1;
        is_load    = 1'b0;
        misaligned = 1'b0;
        case (Opcode)
            OP_LB, OP_LBU:  is_load = 1'b1;
            OP_LH, OP_LHU: begin
                is_load    = 1'b1;
                misaligned = Addr[0];
            end
            OP_LW: begin
                is_load    = 1'b1;
                misaligned = |Addr[1:0];
            end
            OP_SB:          is_load = 1'b0;
            OP_SH:          misaligned = Addr[0];
            OP_SW:          misaligned = |Addr[1:0];
            default:        is_mem = 1'b0;
        endcase
    end

    // Select the addressed lane of read data and extend it per the latched opcode
    always_comb begin
        byte_lane = DMemRData[{lo_q, 3'b000} +: 8];
        half_lane = lo_q[1] ? DMemRData[31:16] : DMemRData[15:0];
        case (op_q)
            OP_LB:   load_ext = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  load_ext = {24'b0, byte_lane};
            OP_LH:   load_ext = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  load_ext = {16'b0, half_lane};
            default: load_ext = DMemRData;
        endcase
    end

    // Next-state, next-output and stall logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        lo_d     = lo_q;
        load_d   = load_q;
        addr_d   = DMemAddr;
        wdata_d  = DMemWData;
        result_d = LoadResult;
        re_d     = DMemRE;
        we_d     = DMemWE;
        rv_d     = 1'b0;
        ae_d     = 1'b0;
        be_d     = 1'b0;
        Stall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Valid && is_mem) begin
                    Stall = 1'b1;
                    if (misaligned) begin
                        state_d = ERR;
                        ae_d    = 1'b1;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                        op_d    = Opcode;
                        lo_d    = Addr[1:0];
                        load_d  = is_load;
                        addr_d  = {Addr[31:2], 2'b00};
                        case (Opcode)
                            OP_SB: begin
                                we_d    = 4'b0001 << Addr[1:0];
                                wdata_d = {4{StoreData[7:0]}};
                            end
                            OP_SH: begin
                                we_d    = Addr[1] ? 4'b1100 : 4'b0011;
                                wdata_d = {2{StoreData[15:0]}};
                            end
                            OP_SW: begin
                                we_d    = 4'b1111;
                                wdata_d = StoreData;
                            end
                            default: re_d = 1'b1;
                        endcase
                    end
                end
            end
            REQ: begin
                Stall = 1'b1;
                if (MemReady) begin
                    state_d = DONE;
                    re_d    = 1'b0;
                    we_d    = 4'b0000;
                    rv_d    = 1'b1;
                    if (load_q) begin
                        result_d = load_ext;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                    re_d    = 1'b0;
                    we_d    = 4'b0000;
                    be_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; synchronous reset wins over all
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= 6'd0;
            lo_q        <= 2'd0;
            load_q      <= 1'b0;
            DMemAddr    <= 32'd0;
            DMemRE      <= 1'b0;
            DMemWE      <= 4'b0000;
            DMemWData   <= 32'd0;
            LoadResult  <= 32'd0;
            ResultValid <= 1'b0;
            AddrError   <= 1'b0;
            BusError    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            lo_q        <= lo_d;
            load_q      <= load_d;
            DMemAddr    <= addr_d;
            DMemRE      <= re_d;
            DMemWE      <= we_d;
            DMemWData   <= wdata_d;
            LoadResult  <= result_d;
            ResultValid <= rv_d;
            AddrError   <= ae_d;
            BusError    <= be_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver queues expected
// completions from an arithmetic reference model, a monitor checks pulses.
module tb_load_store_unit;

    localparam int unsigned TO = 8;

    logic        Clock;
    logic        Reset;
    logic        Valid;
    logic [5:0]  Opcode;
    logic [31:0] Addr;
    logic [31:0] StoreData;
    logic [31:0] DMemAddr;
    logic        DMemRE;
    logic [3:0]  DMemWE;
    logic [31:0] DMemWData;
    logic [31:0] DMemRData;
    logic        MemReady;
    logic [31:0] LoadResult;
    logic        ResultValid;
    logic        Stall;
    logic        AddrError;
    logic        BusError;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .Clock(Clock), .Reset(Reset), .Valid(Valid), .Opcode(Opcode),
        .Addr(Addr), .StoreData(StoreData), .DMemAddr(DMemAddr),
        .DMemRE(DMemRE), .DMemWE(DMemWE), .DMemWData(DMemWData),
        .DMemRData(DMemRData), .MemReady(MemReady), .LoadResult(LoadResult),
        .ResultValid(ResultValid), .Stall(Stall), .AddrError(AddrError),
        .BusError(BusError)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Expected completion: kind bits {bus, addr, result} and LoadResult value
    typedef struct {
        logic [2:0]  kind;
        logic [31:0] result;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] last_load;
    int          checks = 0;
    int          errors = 0;
    logic [5:0]  ops [8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned op_size(input logic [5:0] op);
        case (op)
            6'h20, 6'h24, 6'h28: return 1;
            6'h21, 6'h25, 6'h29: return 2;
            6'h23, 6'h2B:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit op_is_load(input logic [5:0] op);
        return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    endfunction

    function automatic bit op_signed(input logic [5:0] op);
        return op inside {6'h20, 6'h21};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Issue one instruction, act as the memory, and queue its expected completion
    task automatic run_op(input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata,
                          input int delay);
        int unsigned size;
        logic [31:0] off, lane, mask, exp_we, exp_wd;
        exp_t e;
        size      = op_size(op);
        Valid     = 1'b1;
        Opcode    = op;
        Addr      = addr;
        StoreData = sdata;
        MemReady  = 1'b0;
        @(negedge Clock);
        if (size == 0) begin
            check("stall_nonmem", 32'(Stall), 32'd0);
            tick();
            Valid = 1'b0;
            @(negedge Clock);
            check("nonmem_re", 32'(DMemRE), 32'd0);
            check("nonmem_we", 32'(DMemWE), 32'd0);
            tick();
            return;
        end
        check("stall_accept", 32'(Stall), 32'd1);
        if (addr % size != 0) begin
            e.kind   = 3'b010;
            e.result = last_load;
            sb_q.push_back(e);
            tick();
            Valid  = 1'($urandom);
            Opcode = 6'($urandom);
            @(negedge Clock);
            check("err_re", 32'(DMemRE), 32'd0);
            check("err_we", 32'(DMemWE), 32'd0);
            check("err_stall", 32'(Stall), 32'd0);
            tick();
            Valid = 1'b0;
            return;
        end
        off    = addr % 4;
        mask   = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        exp_we = ((32'd1 << size) - 32'd1) << off;
        exp_wd = (size == 1) ? (sdata & 32'hFF) * 32'h0101_0101 :
                 (size == 2) ? (sdata & 32'hFFFF) * 32'h0001_0001 : sdata;
        if (delay < int'(TO)) begin
            if (op_is_load(op)) begin
                lane = (rdata >> (8 * off)) & mask;
                if (op_signed(op) && size < 4 && lane >= (32'd1 << (8 * size - 1)))
                    lane = lane | ~mask;
                last_load = lane;
            end
            e.kind = 3'b001;
        end else begin
            e.kind = 3'b100;
        end
        e.result = last_load;
        sb_q.push_back(e);
        tick();
        for (int i = 0; i < int'(TO); i++) begin
            Valid     = 1'($urandom);
            Opcode    = 6'($urandom);
            Addr      = $urandom;
            MemReady  = (i == delay);
            DMemRData = (i == delay) ? rdata : $urandom;
            @(negedge Clock);
            check("req_addr", DMemAddr, addr - off);
            check("req_re", 32'(DMemRE), op_is_load(op) ? 32'd1 : 32'd0);
            check("req_we", 32'(DMemWE), op_is_load(op) ? 32'd0 : exp_we);
            if (!op_is_load(op)) check("req_wdata", DMemWData, exp_wd);
            check("req_stall", 32'(Stall), 32'd1);
            tick();
            if (i == delay) break;
        end
        MemReady = 1'b0;
        @(negedge Clock);
        check("end_stall", 32'(Stall), 32'd0);
        check("end_re", 32'(DMemRE), 32'd0);
        check("end_we", 32'(DMemWE), 32'd0);
        tick();
        Valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},  DMemAddr, 32'd0);
        check({tag, "_re"},    32'(DMemRE), 32'd0);
        check({tag, "_we"},    32'(DMemWE), 32'd0);
        check({tag, "_wdata"}, DMemWData, 32'd0);
        check({tag, "_ldres"}, LoadResult, 32'd0);
        check({tag, "_rv"},    32'(ResultValid), 32'd0);
        check({tag, "_ae"},    32'(AddrError), 32'd0);
        check({tag, "_be"},    32'(BusError), 32'd0);
        check({tag, "_stall"}, 32'(Stall), 32'd0);
    endtask

    // Monitor: every completion pulse must match the oldest queued expectation
    always @(negedge Clock) begin
        if (!Reset && (ResultValid || AddrError || BusError)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got be/ae/rv=%b%b%b, expected none at %0t",
                         BusError, AddrError, ResultValid, $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_kind", {29'd0, BusError, AddrError, ResultValid}, {29'd0, mon_e.kind});
                check("load_result", LoadResult, mon_e.result);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [5:0]  op;
        logic [31:0] a;
        int          d;
        int unsigned sz;
        Reset     = 1'b1;
        Valid     = 1'b0;
        Opcode    = 6'd0;
        Addr      = 32'd0;
        StoreData = 32'd0;
        DMemRData = 32'd0;
        MemReady  = 1'b0;
        last_load = 32'd0;
        repeat (3) tick();
        @(negedge Clock);
        check_all_zero("reset");
        tick();
        Reset = 1'b0;
        tick();

        run_op(6'h20, 32'h0000_1003, 32'd0, 32'h80FF_1234, 1);
        run_op(6'h25, 32'h0000_1002, 32'd0, 32'h80FF_1234, 0);
        run_op(6'h21, 32'h0000_1002, 32'd0, 32'h80FF_1234, 0);
        run_op(6'h23, 32'h0000_1000, 32'd0, 32'h80FF_1234, 0);
        run_op(6'h28, 32'h0000_2001, 32'h1234_56AB, 32'd0, 0);
        run_op(6'h29, 32'h0000_2002, 32'h0000_1234, 32'd0, 2);
        run_op(6'h23, 32'h0000_1002, 32'd0, 32'd0, 0);
        run_op(6'h29, 32'h0000_2001, 32'h0000_1234, 32'd0, 0);
        run_op(6'h23, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 99);
        run_op(6'h23, 32'h0000_1000, 32'd0, 32'hCAFE_F00D, int'(TO) - 1);
        run_op(6'h00, 32'h0000_1000, 32'd0, 32'd0, 0);

        // Reset in the middle of an outstanding request, with MemReady racing it
        Valid  = 1'b1;
        Opcode = 6'h23;
        Addr   = 32'h0000_3000;
        tick();
        Valid = 1'b0;
        @(negedge Clock);
        check("midreq_re", 32'(DMemRE), 32'd1);
        tick();
        Reset     = 1'b1;
        MemReady  = 1'b1;
        DMemRData = 32'h1111_2222;
        tick();
        @(negedge Clock);
        check_all_zero("midreq_reset");
        tick();
        Reset     = 1'b0;
        MemReady  = 1'b0;
        last_load = 32'd0;
        repeat (3) tick();

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = 6'($urandom); while (op_size(op) != 0);
            end else begin
                op = ops[$urandom_range(0, 7)];
            end
            sz = op_size(op);
            a  = $urandom;
            if (sz != 0 && $urandom_range(0, 2) != 0) a = a - (a % sz);
            case ($urandom_range(0, 9))
                0:       d = int'(TO) + 3;
                1:       d = int'(TO) - 1;
                default: d = $urandom_range(0, 3);
            endcase
            run_op(op, a, $urandom, $urandom, d);
            if ($urandom_range(0, 3) == 0) tick();
        end

        repeat (4) tick();
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
